fetch_stage: RTL and testbench
==============================

FETCH_STAGE -- requirements
Module: fetch_stage

Interface
REQ-001 SHALL have port clk, input, 1: single clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1: reset, asynchronous, active-low; rst=0 forces reset state immediately, independent of clk.
REQ-003 SHALL have port instr_in, input, 16: instruction memory word at address pc_out, valid same cycle.
REQ-004 SHALL have port stall, input, 1: hazard hold request from decode.
REQ-005 SHALL have port branch_taken, input, 1: redirect request from execute.
REQ-006 SHALL have port branch_addr, input, 32: redirect target.
REQ-007 SHALL have port int_req, input, 1: external interrupt request.
REQ-008 SHALL have port pc_out, output, 32: instruction memory address, combinational from state/PC.
REQ-009 SHALL have port if_id_instr, output, 16: registered instruction word to decode (opcode = bits 15:11).
REQ-010 SHALL have port if_id_imm, output, 16: registered immediate word (0 for single-word instructions).
REQ-011 SHALL have port if_id_pc, output, 32: registered address of first word of the instruction.
REQ-012 SHALL have port if_id_valid, output, 1: registered; 0 marks a bubble.

Function
REQ-013 SHALL implement states VEC0, VEC1, FETCH, IMM, IVEC0, IVEC1.
REQ-014 VEC0: pc_out=0, high vector half <= instr_in, go VEC1; stall/branch_taken ignored.
REQ-015 VEC1: pc_out=1, PC <= {high half, instr_in}, go FETCH; stall/branch_taken ignored.
REQ-016 In VEC0/VEC1/IVEC0/IVEC1 if_id_valid SHALL be 0.
REQ-017 FETCH and IMM: pc_out=PC.
REQ-018 FETCH priority SHALL be branch_taken > stall > int_pending > normal fetch.
REQ-019 FETCH, branch_taken=1: PC <= branch_addr, if_id_valid <= 0, stay FETCH.
REQ-020 FETCH, stall=1: PC, state and all if_id_* outputs hold.
REQ-021 FETCH, int_pending=1: if_id_instr <= 16'hF800 (opcode 11111, INT), if_id_imm <= 0, if_id_pc <= PC (return address), if_id_valid <= 1, clear int_pending, go IVEC0; PC not incremented.
REQ-022 FETCH normal, instr_in[15:14]=2'b10 (two-word opcode): pending word <= instr_in, pending pc <= PC, PC <= PC+1, if_id_valid <= 0, go IMM.
REQ-023 FETCH normal, other opcodes: if_id_instr <= instr_in, if_id_imm <= 0, if_id_pc <= PC, if_id_valid <= 1, PC <= PC+1.
REQ-024 IMM, branch_taken=1: discard pending word, PC <= branch_addr, if_id_valid <= 0, go FETCH.
REQ-025 IMM, stall=1: hold PC, pending word, state and if_id_* outputs.
REQ-026 IMM otherwise: if_id_instr <= pending word, if_id_imm <= instr_in, if_id_pc <= pending pc, if_id_valid <= 1, PC <= PC+1, go FETCH.
REQ-027 IVEC0/IVEC1: identical to VEC0/VEC1 with pc_out=2 and 3; IVEC1 goes FETCH.
REQ-028 int_pending SHALL set on any cycle int_req=1 (sticky); set wins over clear in the same cycle.
REQ-029 int_req SHALL only be serviced in FETCH, never between the two words of an instruction.
REQ-030 PC+1 SHALL wrap modulo 2^32 (32'hFFFFFFFF -> 0).
REQ-031 Latency: single-word instruction appears at if_id_* one clk edge after its fetch; two-word one edge after its second word.

Reset
REQ-032 rst=0 SHALL set state=VEC0, PC=0, int_pending=0, pending word/pc=0, all if_id_* outputs=0.
REQ-033 Reset asserted mid-instruction (IMM or IVEC*) SHALL discard all progress; after release fetch restarts at VEC0.

Verification
REQ-034 Reset release, M[0]=16'h0000, M[1]=16'h0010 -> two bubble cycles, then pc_out=32'h10.
REQ-035 M[0x10]=16'h0800 (single-word) -> next edge if_id_instr=16'h0800, if_id_pc=32'h10, valid=1, pc_out=32'h11.
REQ-036 M[0x10]=16'h8000, M[0x11]=16'h1234 -> one bubble, then if_id_instr=16'h8000, if_id_imm=16'h1234, if_id_pc=32'h10, pc_out=32'h12.
REQ-037 stall=1 for 3 cycles in IMM -> pc_out and if_id_* frozen 3 cycles, then REQ-036 result unchanged.
REQ-038 int_req pulse during IMM, M[2]=0, M[3]=16'h0200 -> two-word instruction completes, then if_id_instr=16'hF800 with if_id_pc=next PC, two bubbles, pc_out=32'h200.
REQ-039 branch_taken=1 with branch_addr=32'h40 in IMM with simultaneous stall=1 -> pending word dropped, if_id_valid=0, pc_out=32'h40 next cycle.

Source files
------------

// File: rtl/fetch_stage.sv
// Instruction fetch stage for a 16-bit instruction / 32-bit address machine.
// Fetches one 16-bit word per cycle from pc_out. Two-word instructions
// (instr[15:14] == 2'b10) are assembled across two fetches. Reset and interrupt
// vectors are read as two 16-bit halves: high half first, then low half.
// Reset vector lives at words 0/1 and the interrupt vector at words 2/3.
module fetch_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] instr_in,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_addr,
  input  logic        int_req,
  output logic [31:0] pc_out,
  output logic [15:0] if_id_instr,
  output logic [15:0] if_id_imm,
  output logic [31:0] if_id_pc,
  output logic        if_id_valid
);

  localparam logic [2:0] StVec0  = 3'd0;
  localparam logic [2:0] StVec1  = 3'd1;
  localparam logic [2:0] StFetch = 3'd2;
  localparam logic [2:0] StImm   = 3'd3;
  localparam logic [2:0] StIvec0 = 3'd4;
  localparam logic [2:0] StIvec1 = 3'd5;

  // Synthetic instruction injected into decode when an interrupt is taken.
  localparam logic [15:0] IntInstr = 16'hF800;

  logic [2:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [15:0] vec_hi_q, vec_hi_d;
  logic        int_pending_q, int_pending_d;
  logic        int_clr;
  logic [15:0] pend_instr_q, pend_instr_d;
  logic [31:0] pend_pc_q, pend_pc_d;
  logic [15:0] instr_q, instr_d;
  logic [15:0] imm_q, imm_d;
  logic [31:0] ipc_q, ipc_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_inc;
  logic        two_word;

  assign pc_inc   = pc_q + 32'd1;  // wraps naturally at 2^32
  assign two_word = (instr_in[15:14] == 2'b10);

  // Memory address: fixed vector addresses while loading a vector, PC otherwise.
  always_comb begin
    case (state_q)
      StVec0:  pc_out = 32'd0;
      StVec1:  pc_out = 32'd1;
      StIvec0: pc_out = 32'd2;
      StIvec1: pc_out = 32'd3;
      default: pc_out = pc_q;
    endcase
  end

  // Next-state logic for the sequencer, PC, pending word and IF/ID register.
  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    vec_hi_d     = vec_hi_q;
    pend_instr_d = pend_instr_q;
    pend_pc_d    = pend_pc_q;
    instr_d      = instr_q;
    imm_d        = imm_q;
    ipc_d        = ipc_q;
    valid_d      = valid_q;
    int_clr      = 1'b0;

    case (state_q)
      StVec0: begin
        vec_hi_d = instr_in;
        valid_d  = 1'b0;
        state_d  = StVec1;
      end
      StVec1: begin
        pc_d    = {vec_hi_q, instr_in};
        valid_d = 1'b0;
        state_d = StFetch;
      end
      StIvec0: begin
        vec_hi_d = instr_in;
        valid_d  = 1'b0;
        state_d  = StIvec1;
      end
      StIvec1: begin
        pc_d    = {vec_hi_q, instr_in};
        valid_d = 1'b0;
        state_d = StFetch;
      end
      StFetch: begin
        if (branch_taken) begin
          pc_d    = branch_addr;
          valid_d = 1'b0;
        end else if (stall) begin
          // hold everything
        end else if (int_pending_q) begin
          // PC is left pointing at the next instruction: that is the return address.
          instr_d = IntInstr;
          imm_d   = 16'h0000;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          int_clr = 1'b1;
          state_d = StIvec0;
        end else if (two_word) begin
          pend_instr_d = instr_in;
          pend_pc_d    = pc_q;
          pc_d         = pc_inc;
          valid_d      = 1'b0;
          state_d      = StImm;
        end else begin
          instr_d = instr_in;
          imm_d   = 16'h0000;
          ipc_d   = pc_q;
          valid_d = 1'b1;
          pc_d    = pc_inc;
        end
      end
      StImm: begin
        if (branch_taken) begin
          pend_instr_d = 16'h0000;
          pend_pc_d    = 32'd0;
          pc_d         = branch_addr;
          valid_d      = 1'b0;
          state_d      = StFetch;
        end else if (stall) begin
          // hold everything
        end else begin
          instr_d = pend_instr_q;
          imm_d   = instr_in;
          ipc_d   = pend_pc_q;
          valid_d = 1'b1;
          pc_d    = pc_inc;
          state_d = StFetch;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = StVec0;
      end
    endcase
  end

  // Interrupt request latch: sticky, a new request wins over a same-cycle clear.
  always_comb begin
    int_pending_d = (int_pending_q & ~int_clr) | int_req;
  end

  // State registers with asynchronous active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= StVec0;
      pc_q          <= 32'd0;
      vec_hi_q      <= 16'h0000;
      int_pending_q <= 1'b0;
      pend_instr_q  <= 16'h0000;
      pend_pc_q     <= 32'd0;
      instr_q       <= 16'h0000;
      imm_q         <= 16'h0000;
      ipc_q         <= 32'd0;
      valid_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      vec_hi_q      <= vec_hi_d;
      int_pending_q <= int_pending_d;
      pend_instr_q  <= pend_instr_d;
      pend_pc_q     <= pend_pc_d;
      instr_q       <= instr_d;
      imm_q         <= imm_d;
      ipc_q         <= ipc_d;
      valid_q       <= valid_d;
    end
  end

  assign if_id_instr = instr_q;
  assign if_id_imm   = imm_q;
  assign if_id_pc    = ipc_q;
  assign if_id_valid = valid_q;

endmodule

// File: tb/tb_fetch_stage.sv
// Directed bench for fetch_stage: a small word memory answers pc_out and each
// scenario task checks the IF/ID outputs at the falling edge.
module tb_fetch_stage;

  logic        clk;
  logic        rst;
  logic [15:0] instr_in;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_addr;
  logic        int_req;
  logic [31:0] pc_out;
  logic [15:0] if_id_instr;
  logic [15:0] if_id_imm;
  logic [31:0] if_id_pc;
  logic        if_id_valid;

  logic [15:0] mem [0:1023];
  int checks;
  int errors;

  fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .instr_in    (instr_in),
    .stall       (stall),
    .branch_taken(branch_taken),
    .branch_addr (branch_addr),
    .int_req     (int_req),
    .pc_out      (pc_out),
    .if_id_instr (if_id_instr),
    .if_id_imm   (if_id_imm),
    .if_id_pc    (if_id_pc),
    .if_id_valid (if_id_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Memory read: pc_out only moves at the rising edge, so refresh at the falling edge.
  always @(negedge clk) instr_in = mem[pc_out[9:0]];

  task automatic do_reset();
    rst = 1'b0; stall = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0; int_req = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; stall = 1'b0; branch_taken = 1'b0; branch_addr = 32'd0; int_req = 1'b0;
    #1 rst = 1'b0;
    #1;
    checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL rst_pc got %h want %h", pc_out, 32'd0); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b want 0", if_id_valid); end
    checks++; if (if_id_pc !== 32'd0) begin errors++; $display("FAIL rst_ifpc got %h want 0", if_id_pc); end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (3) @(negedge clk);
    // A single-word instruction has now reached IF/ID; reset asynchronously mid-cycle.
    #2 rst = 1'b0;
    #1;
    checks++; if (pc_out !== 32'd0) begin errors++; $display("FAIL arst_pc got %h want 0", pc_out); end
    checks++; if (if_id_instr !== 16'h0000) begin errors++; $display("FAIL arst_instr got %h want 0000", if_id_instr); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL arst_valid got %b want 0", if_id_valid); end
    checks++; if (if_id_pc !== 32'd0) begin errors++; $display("FAIL arst_ifpc got %h want 0", if_id_pc); end
    @(negedge clk);
  endtask

  task automatic test_boot();
    do_reset();
    @(negedge clk);
    checks++; if (pc_out !== 32'd1) begin errors++; $display("FAIL boot_vec1 got %h want 1", pc_out); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL boot_bub1 got %b want 0", if_id_valid); end
    @(negedge clk);
    checks++; if (pc_out !== 32'h10) begin errors++; $display("FAIL boot_pc got %h want 10", pc_out); end
    checks++; if (if_id_valid !== 1'b0) begin errors++; $display("FAIL boot_bub2 got %b want 0", if_id_valid); end
  endtask

  task automatic test_single();
    mem[10'h10] = 16'h0800; mem[10'h11] = 16'h0801;
    do_reset();
    repeat (3) @(negedge clk);
    checks++; if (if_id_instr !== 16'h0800) begin errors++; $display("FAIL sw_instr got %h want 0800", if_id_instr); end
    checks++; if (if_id_pc !== 32'h10) begin errors++; $display("FAIL sw_pc got %h want 10", if_id_pc); end
    checks++; if (if_id_valid !== 1'b1) begin errors++; $display("FAIL sw_valid got %b want 1", if_id_valid); end
    checks++; if (pc_out !== 32'h11) begin errors++; $display("FAIL sw_pcout got %h want 11", pc_out); end
    stall = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (if_id_instr !== 16'h0800 || if_id_valid !== 1'b1 || pc_out !== 32'h11)
      begin errors++; $display("FAIL sw_stall got %h/%b/%h want 0800/1/11", if_id_instr, if_id_valid, pc_out); end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (if_id_instr !== 16'h0801 || if_id_pc !== 32'h11 || pc_out !== 32'h12)
      begin errors++; $display("FAIL sw_b2b got %h/%h/%h want 0801/11/12", if_id_instr, if_id_pc, pc_out); end
  endtask

  task automatic test_two_word();
    mem[10'h10] = 16'h8000; mem[10'h11] = 16'h1234;
    do_reset();
    repeat (3) @(negedge clk);
    checks++; if (if_id_valid !== 1'b0 || pc_out !== 32'h11)
      begin errors++; $display("FAIL tw_bubble got %b/%h want 0/11", if_id_valid, pc_out); end
    @(negedge clk);
    checks++; if (if_id_instr !== 16'h8000) begin errors++; $display("FAIL tw_instr got %h want 8000", if_id_instr); end
    checks++; if (if_id_imm !== 16'h1234) begin errors++; $display("FAIL tw_imm got %h want 1234", if_id_imm); end
    checks++; if (if_id_pc !== 32'h10 || if_id_valid !== 1'b1)
      begin errors++; $display("FAIL tw_pc got %h/%b want 10/1", if_id_pc, if_id_valid); end
    checks++; if (pc_out !== 32'h12) begin errors++; $display("FAIL tw_pcout got %h want 12", pc_out); end
  endtask

  task automatic test_stall_imm();
    mem[10'h10] = 16'h8000; mem[10'h11] = 16'h1234;
    do_reset();
    repeat (3) @(negedge clk);
    stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++; if (pc_out !== 32'h11 || if_id_valid !== 1'b0 || if_id_instr !== 16'h0000)
        begin errors++; $display("FAIL imm_stall%0d got %h/%b/%h want 11/0/0000", i, pc_out, if_id_valid, if_id_instr); end
    end
    stall = 1'b0;
    @(negedge clk);
    checks++; if (if_id_instr !== 16'h8000 || if_id_imm !== 16'h1234 || if_id_pc !== 32'h10 || pc_out !== 32'h12)
      begin errors++; $display("FAIL imm_after got %h/%h/%h/%h want 8000/1234/10/12", if_id_instr, if_id_imm, if_id_pc, pc_out); end
  endtask

  task automatic test_int_imm();
    mem[10'h10] = 16'h8000; mem[10'h11] = 16'h1234;
    do_reset();
    repeat (3) @(negedge clk);
    int_req = 1'b1;
    @(negedge clk);
    int_req = 1'b0;
    checks++; if (if_id_instr !== 16'h8000 || if_id_valid !== 1'b1 || pc_out !== 32'h12)
      begin errors++; $display("FAIL int_done got %h/%b/%h want 8000/1/12", if_id_instr, if_id_valid, pc_out); end
    @(negedge clk);
    checks++; if (if_id_instr !== 16'hF800 || if_id_imm !== 16'h0000 || if_id_pc !== 32'h12 || if_id_valid !== 1'b1)
      begin errors++; $display("FAIL int_instr got %h/%h/%h/%b want f800/0000/12/1", if_id_instr, if_id_imm, if_id_pc, if_id_valid); end
    checks++; if (pc_out !== 32'd2) begin errors++; $display("FAIL int_ivec0 got %h want 2", pc_out); end
    @(negedge clk);
    checks++; if (if_id_valid !== 1'b0 || pc_out !== 32'd3)
      begin errors++; $display("FAIL int_bub1 got %b/%h want 0/3", if_id_valid, pc_out); end
    @(negedge clk);
    checks++; if (if_id_valid !== 1'b0 || pc_out !== 32'h200)
      begin errors++; $display("FAIL int_target got %b/%h want 0/200", if_id_valid, pc_out); end
  endtask

  task automatic test_int_stall_fetch();
    mem[10'h10] = 16'h0800;
    do_reset();
    repeat (2) @(negedge clk);
    stall = 1'b1; int_req = 1'b1;
    @(negedge clk);
    int_req = 1'b0;
    checks++; if (pc_out !== 32'h10 || if_id_valid !== 1'b0)
      begin errors++; $display("FAIL istall_hold got %h/%b want 10/0", pc_out, if_id_valid); end
    @(negedge clk);
    stall = 1'b0;
    @(negedge clk);
    checks++; if (if_id_instr !== 16'hF800 || if_id_pc !== 32'h10 || pc_out !== 32'd2)
      begin errors++; $display("FAIL istall_int got %h/%h/%h want f800/10/2", if_id_instr, if_id_pc, pc_out); end
  endtask

  task automatic test_branch();
    mem[10'h10] = 16'h8000; mem[10'h40] = 16'h0C00;
    do_reset();
    repeat (3) @(negedge clk);
    branch_taken = 1'b1; branch_addr = 32'h40; stall = 1'b1;
    @(negedge clk);
    branch_taken = 1'b0; stall = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || pc_out !== 32'h40)
      begin errors++; $display("FAIL br_imm got %b/%h want 0/40", if_id_valid, pc_out); end
    @(negedge clk);
    checks++; if (if_id_instr !== 16'h0C00 || if_id_imm !== 16'h0000 || if_id_pc !== 32'h40 || if_id_valid !== 1'b1)
      begin errors++; $display("FAIL br_next got %h/%h/%h/%b want 0c00/0000/40/1", if_id_instr, if_id_imm, if_id_pc, if_id_valid); end
    // Branch in FETCH beats a simultaneous stall; target wraps past 2^32-1.
    mem[10'h3FF] = 16'h0800;
    branch_taken = 1'b1; branch_addr = 32'hFFFF_FFFF; stall = 1'b1;
    @(negedge clk);
    branch_taken = 1'b0; stall = 1'b0;
    checks++; if (if_id_valid !== 1'b0 || pc_out !== 32'hFFFF_FFFF)
      begin errors++; $display("FAIL br_fetch got %b/%h want 0/ffffffff", if_id_valid, pc_out); end
    @(negedge clk);
    checks++; if (if_id_pc !== 32'hFFFF_FFFF || if_id_instr !== 16'h0800 || pc_out !== 32'd0)
      begin errors++; $display("FAIL wrap got %h/%h/%h want ffffffff/0800/0", if_id_pc, if_id_instr, pc_out); end
  endtask

  task automatic test_reset_mid_imm();
    mem[10'h10] = 16'h8000; mem[10'h11] = 16'h1234;
    do_reset();
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (pc_out !== 32'd0 || if_id_valid !== 1'b0)
      begin errors++; $display("FAIL mid_rst got %h/%b want 0/0", pc_out, if_id_valid); end
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (pc_out !== 32'h10 || if_id_valid !== 1'b0)
      begin errors++; $display("FAIL mid_reboot got %h/%b want 10/0", pc_out, if_id_valid); end
    repeat (2) @(negedge clk);
    checks++; if (if_id_instr !== 16'h8000 || if_id_imm !== 16'h1234 || if_id_pc !== 32'h10)
      begin errors++; $display("FAIL mid_refetch got %h/%h/%h want 8000/1234/10", if_id_instr, if_id_imm, if_id_pc); end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    for (int i = 0; i < 1024; i++) mem[i] = 16'h0000;
    mem[0] = 16'h0000; mem[1] = 16'h0010;
    mem[2] = 16'h0000; mem[3] = 16'h0200;
    mem[10'h10] = 16'h0800;
    instr_in = 16'h0000;
    test_reset();
    test_boot();
    test_single();
    test_two_word();
    test_stall_imm();
    test_int_imm();
    test_int_stall_fetch();
    test_branch();
    test_reset_mid_imm();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
